pipe_step_ctrl: RTL and testbench

//  Sequencer for the 5-stage MIPS pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  - Generates the common step enable for free-run or single-step debug mode.
//  - Detects load-use hazards and emits stall (hold PC/IF-ID, bubble ID/EX).
//  - Emits flush on taken jumps.
//  - Halts the pipe when the stop instruction reaches WB.

---
 rtl/pipe_ctrl_pkg.sv | 82 ++++++++
 rtl/load_use_detect.sv | 38 +++
 rtl/pipe_step_ctrl.sv | 124 ++++++++++++
 tb/tb_pipe_step_ctrl.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_pkg
//   Shared definitions for the pipeline step controller:
//   - pipe_state_t     : FSM state encoding (IDLE=0, RUN=1, STEP=2, HALTED=3)
//   - PIPE_ADDR_W      : default register address width
//   - ZERO_REG         : index of the hard-wired zero register
//   - pipe_next_state  : debug-command / stop-flag transition function
//   - pipe_advances    : Moore decode of "latches advance this cycle"
// -----------------------------------------------------------------------------
package pipe_ctrl_pkg;

    localparam int          PIPE_ADDR_W = 5;
    localparam int unsigned ZERO_REG    = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } pipe_state_t;

    // Next state from the current state, the debug commands and the WB stop flag.
    // IDLE honours pause > step > run; RUN lets stop beat pause; HALTED is sticky.
    function automatic pipe_state_t pipe_next_state(
        input pipe_state_t cur,
        input logic        cmd_run,
        input logic        cmd_step,
        input logic        cmd_pause,
        input logic        wb_stop
    );
        pipe_state_t nxt;
        nxt = cur;
        case (cur)
            ST_IDLE: begin
                if (cmd_pause) begin
                    nxt = ST_IDLE;
                end else if (cmd_step) begin
                    nxt = ST_STEP;
                end else if (cmd_run) begin
                    nxt = ST_RUN;
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (wb_stop) begin
                    nxt = ST_HALTED;
                end else if (cmd_pause) begin
                    nxt = ST_IDLE;
                end else begin
                    nxt = ST_RUN;
                end
            end
            ST_STEP: begin
                if (wb_stop) begin
                    nxt = ST_HALTED;
                end else begin
                    nxt = ST_IDLE;
                end
            end
            ST_HALTED: begin
                nxt = ST_HALTED;
            end
            default: begin
                nxt = ST_IDLE;
            end
        endcase
        return nxt;
    endfunction

    // The pipe advances in RUN and in the single STEP cycle only.
    function automatic logic pipe_advances(input pipe_state_t st);
        logic adv;
        case (st)
            ST_RUN:  adv = 1'b1;
            ST_STEP: adv = 1'b1;
            default: adv = 1'b0;
        endcase
        return adv;
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// -----------------------------------------------------------------------------
// load_use_detect
//   Combinational load-use hazard compare between the load sitting in ID/EX
//   and the source registers of the instruction in IF/ID.
// Ports:
//   idex_memread  in   1       ID/EX holds a load
//   idex_rt_addr  in   ADDR_W  load destination register
//   ifid_rs_addr  in   ADDR_W  rs of the IF/ID instruction
//   ifid_rt_addr  in   ADDR_W  rt of the IF/ID instruction
//   ifid_uses_rt  in   1       IF/ID instruction actually reads rt
//   hazard        out  1       load-use hazard present
// -----------------------------------------------------------------------------
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = PIPE_ADDR_W
) (
    input  logic              idex_memread,
    input  logic [ADDR_W-1:0] idex_rt_addr,
    input  logic [ADDR_W-1:0] ifid_rs_addr,
    input  logic [ADDR_W-1:0] ifid_rt_addr,
    input  logic              ifid_uses_rt,
    output logic              hazard
);

    logic dest_live_s;
    logic rs_match_s;
    logic rt_match_s;

    // A load into the zero register never produces a value, so it cannot hazard.
    assign dest_live_s = (idex_rt_addr != ADDR_W'(ZERO_REG));
    assign rs_match_s  = (idex_rt_addr == ifid_rs_addr);
    // rt only matters when the consumer really reads it (not for I-type targets).
    assign rt_match_s  = ifid_uses_rt & (idex_rt_addr == ifid_rt_addr);

    assign hazard = idex_memread & dest_live_s & (rs_match_s | rt_match_s);

endmodule

// File: rtl/pipe_step_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_step_ctrl
//   Sequencer for the 5-stage MIPS pipeline latches. Produces the common step
//   enable (free-run or single-step debug), load-use stall, jump flush and the
//   halt indication once the stop instruction reaches WB.
//
// Optional feature macro: PIPE_CYCLE_COUNT_EN
//   defined   -> o_cycle_count counts cycles with o_step=1, saturating
//   undefined -> o_cycle_count tied to zero, no counter flops
//
// Ports:
//   clk             in   1       clock, rising edge
//   rst             in   1       synchronous reset, active-high
//   i_cmd_run       in   1       debug pulse: enter free-run
//   i_cmd_step      in   1       debug pulse: advance exactly one cycle
//   i_cmd_pause     in   1       debug pulse: leave free-run
//   i_idex_memread  in   1       ID/EX holds a load
//   i_idex_rt_addr  in   ADDR_W  load destination in ID/EX
//   i_ifid_rs_addr  in   ADDR_W  rs of IF/ID instruction
//   i_ifid_rt_addr  in   ADDR_W  rt of IF/ID instruction
//   i_ifid_uses_rt  in   1       IF/ID instruction reads rt
//   i_jump_taken    in   1       jump/branch resolved taken in ID
//   i_wb_stop_pipe  in   1       stop flag at MEM/WB output
//   o_step          out  1       latch/PC advance enable
//   o_stall         out  1       hold PC + IF/ID, bubble ID/EX
//   o_flush         out  1       clear IF/ID and ID/EX
//   o_step_done     out  1       pulse in the single-step cycle
//   o_halted        out  1       pipe stopped by stop instruction
//   o_state         out  2       FSM state for debug readout
//   o_cycle_count   out  CNT_W   executed steps (macro only)
// -----------------------------------------------------------------------------
module pipe_step_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ADDR_W = PIPE_ADDR_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_cmd_run,
    input  logic              i_cmd_step,
    input  logic              i_cmd_pause,
    input  logic              i_idex_memread,
    input  logic [ADDR_W-1:0] i_idex_rt_addr,
    input  logic [ADDR_W-1:0] i_ifid_rs_addr,
    input  logic [ADDR_W-1:0] i_ifid_rt_addr,
    input  logic              i_ifid_uses_rt,
    input  logic              i_jump_taken,
    input  logic              i_wb_stop_pipe,
    output logic              o_step,
    output logic              o_stall,
    output logic              o_flush,
    output logic              o_step_done,
    output logic              o_halted,
    output logic [1:0]        o_state,
    output logic [CNT_W-1:0]  o_cycle_count
);

    pipe_state_t state_r;
    pipe_state_t state_next_s;
    logic        step_r;
    logic        step_done_r;
    logic        halted_r;
    logic        hz_s;

    assign state_next_s = pipe_next_state(state_r, i_cmd_run, i_cmd_step,
                                          i_cmd_pause, i_wb_stop_pipe);

    // FSM: state plus its Moore outputs, decoded from the next state so that
    // they are flops yet line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            step_r      <= 1'b0;
            step_done_r <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            step_r      <= pipe_advances(state_next_s);
            step_done_r <= (state_next_s == ST_STEP);
            halted_r    <= (state_next_s == ST_HALTED);
        end
    end

    load_use_detect #(
        .ADDR_W (ADDR_W)
    ) u_load_use_detect (
        .idex_memread (i_idex_memread),
        .idex_rt_addr (i_idex_rt_addr),
        .ifid_rs_addr (i_ifid_rs_addr),
        .ifid_rt_addr (i_ifid_rt_addr),
        .ifid_uses_rt (i_ifid_uses_rt),
        .hazard       (hz_s)
    );

    assign o_step      = step_r;
    assign o_step_done = step_done_r;
    assign o_halted    = halted_r;
    assign o_state     = state_r;
    // Hazard terms are only meaningful while the latches move; a flush already
    // discards the dependent instruction, so it suppresses the stall.
    assign o_flush     = step_r & i_jump_taken;
    assign o_stall     = step_r & hz_s & ~i_jump_taken;

`ifdef PIPE_CYCLE_COUNT_EN
    logic [CNT_W-1:0] cycle_count_r;

    // Saturating count of cycles in which the pipe advanced.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_count_r <= {CNT_W{1'b0}};
        end else if (step_r && (cycle_count_r != {CNT_W{1'b1}})) begin
            cycle_count_r <= cycle_count_r + CNT_W'(1);
        end else begin
            cycle_count_r <= cycle_count_r;
        end
    end

    assign o_cycle_count = cycle_count_r;
`else
    assign o_cycle_count = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_step_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_step_ctrl
//   Self-checking bench for pipe_step_ctrl: hand-written mode sequences, a
//   table of hazard vectors applied in RUN, and a randomized run checked
//   against a mode/flag reference model.
// -----------------------------------------------------------------------------
module tb_pipe_step_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_run, cmd_step, cmd_pause;
    logic        idex_memread, ifid_uses_rt, jump_taken, wb_stop_pipe;
    logic [4:0]  idex_rt_addr, ifid_rs_addr, ifid_rt_addr;
    logic        step, stall, flush, step_done, halted;
    logic [1:0]  state;
    logic [31:0] cycle_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    pipe_step_ctrl #(.ADDR_W(5), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_cmd_run      (cmd_run),
        .i_cmd_step     (cmd_step),
        .i_cmd_pause    (cmd_pause),
        .i_idex_memread (idex_memread),
        .i_idex_rt_addr (idex_rt_addr),
        .i_ifid_rs_addr (ifid_rs_addr),
        .i_ifid_rt_addr (ifid_rt_addr),
        .i_ifid_uses_rt (ifid_uses_rt),
        .i_jump_taken   (jump_taken),
        .i_wb_stop_pipe (wb_stop_pipe),
        .o_step         (step),
        .o_stall        (stall),
        .o_flush        (flush),
        .o_step_done    (step_done),
        .o_halted       (halted),
        .o_state        (state),
        .o_cycle_count  (cycle_count)
    );

    typedef struct {
        logic       memread;
        logic [4:0] idex_rt;
        logic [4:0] ifid_rs;
        logic [4:0] ifid_rt;
        logic       uses_rt;
        logic       jump;
        logic       exp_stall;
        logic       exp_flush;
    } hz_vec_t;

    // Reference model: abstract mode flags rather than a state register.
    bit     m_running, m_single, m_halted;
    longint m_count;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input longint n);
`ifdef PIPE_CYCLE_COUNT_EN
        longint sat;
        sat = (n > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : n;
        return sat[31:0];
`else
        return 32'd0 + 32'(n & 64'd0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        rst = 1'b0; cmd_run = 1'b0; cmd_step = 1'b0; cmd_pause = 1'b0;
        idex_memread = 1'b0; ifid_uses_rt = 1'b0; jump_taken = 1'b0; wb_stop_pipe = 1'b0;
        idex_rt_addr = 5'd0; ifid_rs_addr = 5'd0; ifid_rt_addr = 5'd0;
    endtask

    task automatic do_reset();
        quiet_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic start_run();
        cmd_run = 1'b1;
        tick();
        cmd_run = 1'b0;
        #1;
    endtask

    function automatic bit model_hz(input logic mr, input logic [4:0] irt,
                                    input logic [4:0] rs, input logic [4:0] rt, input logic ur);
        return mr && (irt != 5'd0) && ((irt == rs) || (ur && (irt == rt)));
    endfunction

    // Compare every output with the model for the current cycle.
    task automatic model_compare();
        bit       adv;
        logic [1:0] st;
        adv = m_running || m_single;
        st  = m_halted ? 2'd3 : (m_single ? 2'd2 : (m_running ? 2'd1 : 2'd0));
        check("rnd_state", state, st);
        check("rnd_step", step, adv);
        check("rnd_done", step_done, m_single);
        check("rnd_halted", halted, m_halted);
        check("rnd_flush", flush, adv && jump_taken);
        check("rnd_stall", stall, adv && !jump_taken &&
              model_hz(idex_memread, idex_rt_addr, ifid_rs_addr, ifid_rt_addr, ifid_uses_rt));
        check("rnd_count", cycle_count, exp_cnt(m_count));
    endtask

    // Apply the rules of the clock edge to the model using the held inputs.
    task automatic model_edge();
        if (rst) begin
            m_running = 0; m_single = 0; m_halted = 0; m_count = 0;
        end else begin
            if (m_running || m_single) m_count++;
            if (m_halted) begin
                m_halted = 1;
            end else if (m_single) begin
                m_single = 0;
                m_halted = wb_stop_pipe;
            end else if (m_running) begin
                if (wb_stop_pipe) begin
                    m_running = 0; m_halted = 1;
                end else if (cmd_pause) begin
                    m_running = 0;
                end
            end else if (!cmd_pause) begin
                if (cmd_step) m_single = 1;
                else if (cmd_run) m_running = 1;
            end
        end
    endtask

    initial begin
        hz_vec_t vecs[8];
        vecs[0] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[1] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 5'd5, 5'd3, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 5'd5, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 5'd5, 5'd5, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7] = '{1'b1, 5'd7, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        check("rst_state", state, 2'd0);
        check("rst_step", step, 1'b0);
        check("rst_stall", stall, 1'b0);
        check("rst_flush", flush, 1'b0);
        check("rst_done", step_done, 1'b0);
        check("rst_halted", halted, 1'b0);
        check("rst_count", cycle_count, 32'd0);

        // Single step: pulse, one advancing cycle, back to IDLE
        repeat (3) tick();
        check("idle_nostep", step, 1'b0);
        cmd_step = 1'b1;
        tick();
        cmd_step = 1'b0;
        #1;
        check("sstep_step", step, 1'b1);
        check("sstep_done", step_done, 1'b1);
        check("sstep_state", state, 2'd2);
        tick();
        check("sstep_after_step", step, 1'b0);
        check("sstep_after_done", step_done, 1'b0);
        check("sstep_after_state", state, 2'd0);
        check("sstep_count", cycle_count, exp_cnt(1));

        // Run to stop in the 10th RUN cycle
        do_reset();
        start_run();
        check("run_state", state, 2'd1);
        check("run_step", step, 1'b1);
        repeat (9) tick();
        check("run10_step", step, 1'b1);
        wb_stop_pipe = 1'b1;
        tick();
        wb_stop_pipe = 1'b0;
        #1;
        check("stop_halted", halted, 1'b1);
        check("stop_state", state, 2'd3);
        check("stop_step", step, 1'b0);
        check("stop_count", cycle_count, exp_cnt(10));
        cmd_run = 1'b1; cmd_step = 1'b1;
        tick();
        cmd_run = 1'b0; cmd_step = 1'b0;
        tick();
        check("halt_ignores_cmd", state, 2'd3);
        check("halt_step", step, 1'b0);
        check("halt_count", cycle_count, exp_cnt(10));

        // Hazard vectors in RUN
        do_reset();
        start_run();
        foreach (vecs[i]) begin
            idex_memread = vecs[i].memread;
            idex_rt_addr = vecs[i].idex_rt;
            ifid_rs_addr = vecs[i].ifid_rs;
            ifid_rt_addr = vecs[i].ifid_rt;
            ifid_uses_rt = vecs[i].uses_rt;
            jump_taken   = vecs[i].jump;
            #1;
            check($sformatf("vec%0d_stall", i), stall, vecs[i].exp_stall);
            check($sformatf("vec%0d_flush", i), flush, vecs[i].exp_flush);
            tick();
        end

        // Same jump+hazard inputs in IDLE: nothing asserted
        quiet_inputs();
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        idex_memread = 1'b1; idex_rt_addr = 5'd5; ifid_rs_addr = 5'd5; jump_taken = 1'b1;
        #1;
        check("idle_state", state, 2'd0);
        check("idle_flush", flush, 1'b0);
        check("idle_stall", stall, 1'b0);
        jump_taken = 1'b0;
        #1;
        check("idle_stall_nojump", stall, 1'b0);
        quiet_inputs();

        // pause+step+run together in RUN -> IDLE
        start_run();
        tick();
        cmd_pause = 1'b1; cmd_step = 1'b1; cmd_run = 1'b1;
        tick();
        quiet_inputs();
        #1;
        check("all_cmds_state", state, 2'd0);
        check("all_cmds_step", step, 1'b0);

        // rst during RUN
        start_run();
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_state", state, 2'd0);
        check("midrst_count", cycle_count, 32'd0);

        // stop + pause together in RUN -> HALTED
        start_run();
        wb_stop_pipe = 1'b1; cmd_pause = 1'b1;
        tick();
        quiet_inputs();
        #1;
        check("stop_pause_state", state, 2'd3);
        check("stop_pause_halted", halted, 1'b1);

        // Randomized run against the reference model
        do_reset();
        m_running = 0; m_single = 0; m_halted = 0; m_count = 0;
        for (int c = 0; c < 1500; c++) begin
            rst          = ($urandom_range(0, 59) == 0);
            cmd_run      = ($urandom_range(0, 5) == 0);
            cmd_step     = ($urandom_range(0, 5) == 0);
            cmd_pause    = ($urandom_range(0, 7) == 0);
            wb_stop_pipe = ($urandom_range(0, 39) == 0);
            idex_memread = $urandom_range(0, 1);
            idex_rt_addr = 5'($urandom_range(0, 3));
            ifid_rs_addr = 5'($urandom_range(0, 3));
            ifid_rt_addr = 5'($urandom_range(0, 3));
            ifid_uses_rt = $urandom_range(0, 1);
            jump_taken   = ($urandom_range(0, 3) == 0);
            #1;
            model_compare();
            model_edge();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
